// File: rtl/rp_delay_mc_pkg.sv
// -----------------------------------------------------------------------------
// rp_delay_pkg
// Shared definitions for the multi-channel ADC delay line (rp_delay_mc):
//   - trigger source codes used to index the delay table
//   - dly_entry_t, one delay-table entry {keep, dly}
//   - dly_default(), the power-on contents of each table entry
// Optional feature macro used by this slice: RP_DELAY_MC_OVR_EN (see rp_delay_mc).
// -----------------------------------------------------------------------------
package rp_delay_pkg;

    localparam int TRG_W       = 4;           // width of a trigger source code
    localparam int N_SRC       = 1 << TRG_W;  // number of delay-table entries
    localparam int DLY_FIELD_W = 8;           // storage width of dly in dly_entry_t

    typedef enum logic [TRG_W-1:0] {
        TRG_MANUAL  = 4'd0,
        TRG_NOW     = 4'd1,
        TRG_CHA_PE  = 4'd2,
        TRG_CHA_NE  = 4'd3,
        TRG_CHB_PE  = 4'd4,
        TRG_CHB_NE  = 4'd5,
        TRG_EXT_PE  = 4'd6,
        TRG_EXT_NE  = 4'd7,
        TRG_ASG_PE  = 4'd8,
        TRG_ASG_NE  = 4'd9,
        TRG_CHC_PE  = 4'd10,
        TRG_CHC_NE  = 4'd11,
        TRG_CHD_PE  = 4'd12,
        TRG_CHD_NE  = 4'd13,
        TRG_RSVD_14 = 4'd14,
        TRG_RSVD_15 = 4'd15
    } trg_src_e;

    // keep=1 means "selecting this source leaves the applied delay alone".
    typedef struct packed {
        logic                   keep;
        logic [DLY_FIELD_W-1:0] dly;
    } dly_entry_t;

    // Level-style channel sources get one tap, external/ASG sources two taps,
    // manual/now/reserved sources keep whatever delay is already applied.
    function automatic dly_entry_t dly_default(input logic [TRG_W-1:0] src);
        dly_entry_t e;
        e.keep = 1'b1;
        e.dly  = '0;
        case (src)
            TRG_CHA_PE, TRG_CHA_NE, TRG_CHB_PE, TRG_CHB_NE,
            TRG_CHC_PE, TRG_CHC_NE, TRG_CHD_PE, TRG_CHD_NE: begin
                e.keep = 1'b0;
                e.dly  = 8'd1;
            end
            TRG_EXT_PE, TRG_EXT_NE, TRG_ASG_PE, TRG_ASG_NE: begin
                e.keep = 1'b0;
                e.dly  = 8'd2;
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rp_delay_mc_if.sv
// -----------------------------------------------------------------------------
// rp_delay_mc_if
// Signal bundle of the ADC delay line. The "slave" modport is the delay block,
// the "master" modport is whoever feeds samples / configuration and consumes
// the delayed stream.
//   dly_dat_i/dly_val_i        : input samples (channel k at [k*DW +: DW]) + valid
//   set_trg_src_i/set_trg_new_i: trigger source code and its one-cycle strobe
//   cfg_we_i/cfg_src_i/cfg_dly_i/cfg_keep_i : delay-table write port
//   dly_dat_o/dly_val_o        : delayed samples and valid (registered)
//   dly_valp_o                 : delayed valid one cycle early (combinational)
//   cur_dly_o                  : delay currently applied
//   ovr_en_i/ovr_dly_i         : delay override, only with RP_DELAY_MC_OVR_EN
// -----------------------------------------------------------------------------
interface rp_delay_mc_if
    import rp_delay_pkg::*;
#(
    parameter int DW   = 14,
    parameter int CH   = 2,
    parameter int DLYW = 3
) ();

    logic [CH*DW-1:0] dly_dat_i;
    logic             dly_val_i;
    logic [TRG_W-1:0] set_trg_src_i;
    logic             set_trg_new_i;
    logic             cfg_we_i;
    logic [TRG_W-1:0] cfg_src_i;
    logic [DLYW-1:0]  cfg_dly_i;
    logic             cfg_keep_i;
    logic [CH*DW-1:0] dly_dat_o;
    logic             dly_val_o;
    logic             dly_valp_o;
    logic [DLYW-1:0]  cur_dly_o;
`ifdef RP_DELAY_MC_OVR_EN
    logic             ovr_en_i;
    logic [DLYW-1:0]  ovr_dly_i;
`endif

    modport master (
`ifdef RP_DELAY_MC_OVR_EN
        output ovr_en_i,
        output ovr_dly_i,
`endif
        output dly_dat_i,
        output dly_val_i,
        output set_trg_src_i,
        output set_trg_new_i,
        output cfg_we_i,
        output cfg_src_i,
        output cfg_dly_i,
        output cfg_keep_i,
        input  dly_dat_o,
        input  dly_val_o,
        input  dly_valp_o,
        input  cur_dly_o
    );

    modport slave (
`ifdef RP_DELAY_MC_OVR_EN
        input  ovr_en_i,
        input  ovr_dly_i,
`endif
        input  dly_dat_i,
        input  dly_val_i,
        input  set_trg_src_i,
        input  set_trg_new_i,
        input  cfg_we_i,
        input  cfg_src_i,
        input  cfg_dly_i,
        input  cfg_keep_i,
        output dly_dat_o,
        output dly_val_o,
        output dly_valp_o,
        output cur_dly_o
    );

endinterface

// File: rtl/rp_delay_mc_tap.sv
// -----------------------------------------------------------------------------
// rp_delay_tap
// One lane of the delay line: a DEPTH-deep shift register that advances every
// clock, a tap mux selected by sel, and a registered copy of the mux output.
//   adc_clk_i, adc_rstn_i : clock, asynchronous active-low reset
//   din                   : lane input, captured into tap 0 every cycle
//   sel                   : tap index (0 = most recent sample)
//   pass                  : gates the mux; low forces both outputs to 0
//   dout_comb             : gated mux output, same cycle
//   dout_reg              : dout_comb delayed by one register
// -----------------------------------------------------------------------------
module rp_delay_tap #(
    parameter int W     = 14,
    parameter int DEPTH = 8,
    parameter int DLYW  = $clog2(DEPTH)
) (
    input  logic            adc_clk_i,
    input  logic            adc_rstn_i,
    input  logic [W-1:0]    din,
    input  logic [DLYW-1:0] sel,
    input  logic            pass,
    output logic [W-1:0]    dout_comb,
    output logic [W-1:0]    dout_reg
);

    logic [W-1:0] tap_reg [DEPTH];

    // Shifting is unconditional: the delay is measured in clocks, not samples.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_reg[i] <= '0;
            end
            dout_reg <= '0;
        end else begin
            tap_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                tap_reg[i] <= tap_reg[i-1];
            end
            dout_reg <= dout_comb;
        end
    end

    // DEPTH is a power of two, so every sel value addresses a real tap.
    assign dout_comb = pass ? tap_reg[sel] : '0;

endmodule

// File: rtl/rp_delay_mc.sv
// -----------------------------------------------------------------------------
// rp_delay_mc
// Multi-channel ADC delay line that aligns CH channels to the trigger instant.
// A 16-entry table maps the last trigger source to a delay (or to "keep the
// current delay"); any change of the applied delay masks the output valid for
// new_delay+1 cycles while the taps refill.
//   adc_clk_i  : ADC clock (only clock of the block)
//   adc_rstn_i : asynchronous active-low reset; also restores table defaults
//   bus        : rp_delay_mc_if.slave, see the interface for the signal list
// Optional feature: define RP_DELAY_MC_OVR_EN to add ovr_en_i/ovr_dly_i, which
// force the applied delay while ovr_en_i is high.
// -----------------------------------------------------------------------------
module rp_delay_mc
    import rp_delay_pkg::*;
#(
    parameter int DW    = 14,
    parameter int CH    = 2,
    parameter int DEPTH = 8,
    parameter int DLYW  = $clog2(DEPTH)
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    rp_delay_mc_if.slave  bus
);

    // The default-table field is DLY_FIELD_W bits wide, hence the upper bound.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (1 << DLY_FIELD_W)
        || DLYW != $clog2(DEPTH)) begin : g_bad_cfg
        $error("rp_delay_mc: DEPTH must be a power of two >= 2 and DLYW must stay derived");
    end

    logic [TRG_W-1:0] last_src_reg;
    logic [DLYW-1:0]  cur_dly_reg;
    logic [DLYW-1:0]  cur_dly_next;
    logic [DLYW:0]    hold_reg;      // needs DLYW+1 bits: holds up to DEPTH
    logic [DLYW:0]    hold_next;
    logic             hold_zero;

    logic [DLYW-1:0]  tbl_dly  [N_SRC];
    logic             tbl_keep [N_SRC];

    // ---------------------------------------------------------------- table
    // One register pair per entry so each entry can reset to its own default.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_tbl
        localparam dly_entry_t DEF = dly_default(TRG_W'(gi));

        logic [DLYW-1:0] dly_reg;
        logic            keep_reg;

        always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
            if (!adc_rstn_i) begin
                dly_reg  <= DLYW'(DEF.dly);
                keep_reg <= DEF.keep;
            end else if (bus.cfg_we_i && (bus.cfg_src_i == TRG_W'(gi))) begin
                dly_reg  <= bus.cfg_dly_i;
                keep_reg <= bus.cfg_keep_i;
            end
        end

        assign tbl_dly[gi]  = dly_reg;
        assign tbl_keep[gi] = keep_reg;
    end

    // ------------------------------------------------- delay select + hold
    always_comb begin
        cur_dly_next = cur_dly_reg;
        hold_next    = hold_reg;

`ifdef RP_DELAY_MC_OVR_EN
        if (bus.ovr_en_i) begin
            cur_dly_next = bus.ovr_dly_i;
        end else if (!tbl_keep[last_src_reg]) begin
            cur_dly_next = tbl_dly[last_src_reg];
        end
`else
        if (!tbl_keep[last_src_reg]) begin
            cur_dly_next = tbl_dly[last_src_reg];
        end
`endif

        // Taps beyond the old delay may hold samples that never made it
        // through the new alignment, so wait until new_dly+1 fresh ones passed.
        if (cur_dly_next != cur_dly_reg) begin
            hold_next = {1'b0, cur_dly_next} + (DLYW+1)'(1);
        end else if (hold_reg != '0) begin
            hold_next = hold_reg - (DLYW+1)'(1);
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            last_src_reg <= '0;
            cur_dly_reg  <= '0;
            hold_reg     <= '0;
        end else begin
            if (bus.set_trg_new_i) begin
                last_src_reg <= bus.set_trg_src_i;
            end
            cur_dly_reg <= cur_dly_next;
            hold_reg    <= hold_next;
        end
    end

    assign hold_zero = (hold_reg == '0);

    // ------------------------------------------------------------ datapath
    logic [CH*DW-1:0] dat_q;
    logic [CH*DW-1:0] dat_comb_unused;   // data lanes only use the registered tap
    logic             val_p;
    logic             val_q;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        rp_delay_tap #(
            .W     (DW),
            .DEPTH (DEPTH),
            .DLYW  (DLYW)
        ) u_tap (
            .adc_clk_i  (adc_clk_i),
            .adc_rstn_i (adc_rstn_i),
            .din        (bus.dly_dat_i[gi*DW +: DW]),
            .sel        (cur_dly_reg),
            .pass       (1'b1),
            .dout_comb  (dat_comb_unused[gi*DW +: DW]),
            .dout_reg   (dat_q[gi*DW +: DW])
        );
    end

    // Valid lane: the hold-off mask is applied before the register so that
    // dly_valp_o is exactly dly_val_o one cycle early.
    rp_delay_tap #(
        .W     (1),
        .DEPTH (DEPTH),
        .DLYW  (DLYW)
    ) u_val_tap (
        .adc_clk_i  (adc_clk_i),
        .adc_rstn_i (adc_rstn_i),
        .din        (bus.dly_val_i),
        .sel        (cur_dly_reg),
        .pass       (hold_zero),
        .dout_comb  (val_p),
        .dout_reg   (val_q)
    );

    assign bus.dly_dat_o  = dat_q;
    assign bus.dly_val_o  = val_q;
    assign bus.dly_valp_o = val_p;
    assign bus.cur_dly_o  = cur_dly_reg;

endmodule

// File: tb/tb_rp_delay_mc.sv
// -----------------------------------------------------------------------------
// tb_rp_delay_mc
// Scoreboard bench for rp_delay_mc. A reference process rebuilds the expected
// output from the input history (output = input from cur_dly+2 cycles ago,
// valid masked during hold-off) and queues one expected record per clock; a
// monitor pops and compares on the opposite clock edge.
// Builds with or without RP_DELAY_MC_OVR_EN.
// -----------------------------------------------------------------------------
module tb_rp_delay_mc;

    localparam int DW    = 14;
    localparam int CH    = 2;
    localparam int DEPTH = 8;
    localparam int DLYW  = $clog2(DEPTH);

    typedef struct {
        logic [CH*DW-1:0] dat;
        logic             val;
        logic             valp;
        logic [DLYW-1:0]  dly;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks   = 0;
    int failures = 0;
    int ramp     = 0;
    bit rand_mode = 1'b0;

    rp_delay_mc_if #(.DW(DW), .CH(CH), .DLYW(DLYW)) bus ();

    rp_delay_mc #(
        .DW    (DW),
        .CH    (CH),
        .DEPTH (DEPTH)
    ) dut (
        .adc_clk_i  (clk),
        .adc_rstn_i (rst_n),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------ reference model
    exp_t             exp_q [$];
    logic [CH*DW-1:0] m_dat_hist [$];   // [i] = sample taken i+1 clocks ago
    logic             m_val_hist [$];
    int               m_tbl_dly  [16];
    bit               m_tbl_keep [16];
    int               m_last_src;
    int               m_cur;
    int               m_hold;

    function automatic void model_reset();
        exp_q.delete();
        m_dat_hist.delete();
        m_val_hist.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_dat_hist.push_back('0);
            m_val_hist.push_back(1'b0);
        end
        for (int s = 0; s < 16; s++) begin
            if ((s >= 2 && s <= 5) || (s >= 10 && s <= 13)) begin
                m_tbl_dly[s] = 1; m_tbl_keep[s] = 1'b0;
            end else if (s >= 6 && s <= 9) begin
                m_tbl_dly[s] = 2; m_tbl_keep[s] = 1'b0;
            end else begin
                m_tbl_dly[s] = 0; m_tbl_keep[s] = 1'b1;
            end
        end
        m_last_src = 0;
        m_cur      = 0;
        m_hold     = 0;
    endfunction

    initial begin
        exp_t e;
        int   d_old;
        int   d_new;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                d_old  = m_cur;
                // Registered output after this edge reflects the tap and hold
                // state that were in force during the cycle just ended.
                e.dat  = m_dat_hist[d_old];
                e.val  = m_val_hist[d_old] && (m_hold == 0);
                m_dat_hist.push_front(bus.dly_dat_i);
                m_val_hist.push_front(bus.dly_val_i);

                d_new = d_old;
`ifdef RP_DELAY_MC_OVR_EN
                if (bus.ovr_en_i) d_new = int'(bus.ovr_dly_i);
                else if (!m_tbl_keep[m_last_src]) d_new = m_tbl_dly[m_last_src];
`else
                if (!m_tbl_keep[m_last_src]) d_new = m_tbl_dly[m_last_src];
`endif
                if (d_new != d_old) m_hold = d_new + 1;
                else if (m_hold > 0) m_hold = m_hold - 1;
                m_cur = d_new;

                if (bus.cfg_we_i) begin
                    m_tbl_dly[bus.cfg_src_i]  = int'(bus.cfg_dly_i);
                    m_tbl_keep[bus.cfg_src_i] = bus.cfg_keep_i;
                end
                if (bus.set_trg_new_i) m_last_src = int'(bus.set_trg_src_i);

                e.valp = m_val_hist[d_new] && (m_hold == 0);
                e.dly  = DLYW'(d_new);
                void'(m_dat_hist.pop_back());
                void'(m_val_hist.pop_back());
                exp_q.push_back(e);
            end
        end
    end

    // -------------------------------------------------------------- monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.dly_dat_o !== e.dat || bus.dly_val_o !== e.val ||
                    bus.dly_valp_o !== e.valp || bus.cur_dly_o !== e.dly) begin
                    failures++;
                    $display("FAIL cycle_out t=%0t got dat=%h val=%b valp=%b dly=%0d required dat=%h val=%b valp=%b dly=%0d",
                             $time, bus.dly_dat_o, bus.dly_val_o, bus.dly_valp_o, bus.cur_dly_o,
                             e.dat, e.val, e.valp, e.dly);
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, got, req);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dat"},  32'(bus.dly_dat_o),  32'd0);
        chk({tag, "_val"},  32'(bus.dly_val_o),  32'd0);
        chk({tag, "_valp"}, 32'(bus.dly_valp_o), 32'd0);
        chk({tag, "_dly"},  32'(bus.cur_dly_o),  32'd0);
    endtask

    task automatic step(input bit trg, input int src, input bit we,
                        input int ws, input int wd, input bit wk);
        logic [CH*DW-1:0] d;
        @(posedge clk);
        #1;
        if (rand_mode) begin
            d = (CH*DW)'({$urandom(), $urandom()});
            bus.dly_val_i = ($urandom_range(0, 3) != 0);
        end else begin
            for (int k = 0; k < CH; k++) d[k*DW +: DW] = DW'(ramp + k * 1000);
            bus.dly_val_i = ((ramp % 5) != 0);
        end
        ramp++;
        bus.dly_dat_i     = d;
        bus.set_trg_new_i = trg;
        bus.set_trg_src_i = 4'(src);
        bus.cfg_we_i      = we;
        bus.cfg_src_i     = 4'(ws);
        bus.cfg_dly_i     = DLYW'(wd);
        bus.cfg_keep_i    = wk;
        if (trg) $display("trigger src=%0d t=%0t", src, $time);
        if (we)  $display("cfg write src=%0d dly=%0d keep=%0d t=%0t", ws, wd, wk, $time);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_cycles(input int n);
        bit trg, we;
        for (int i = 0; i < n; i++) begin
            trg = ($urandom_range(0, 11) == 0);
            we  = ($urandom_range(0, 15) == 0);
`ifdef RP_DELAY_MC_OVR_EN
            if ($urandom_range(0, 39) == 0) bus.ovr_en_i = ~bus.ovr_en_i;
            bus.ovr_dly_i = DLYW'($urandom_range(0, DEPTH - 1));
`endif
            step(trg, $urandom_range(0, 15), we, $urandom_range(0, 15),
                 $urandom_range(0, DEPTH - 1), ($urandom_range(0, 3) == 0));
        end
`ifdef RP_DELAY_MC_OVR_EN
        bus.ovr_en_i = 1'b0;
`endif
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        $display("reset asserted (%s) t=%0t", tag, $time);
        #1;
        chk_zero_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.dly_dat_i     = '0;
        bus.dly_val_i     = 1'b0;
        bus.set_trg_src_i = '0;
        bus.set_trg_new_i = 1'b0;
        bus.cfg_we_i      = 1'b0;
        bus.cfg_src_i     = '0;
        bus.cfg_dly_i     = '0;
        bus.cfg_keep_i    = 1'b0;
`ifdef RP_DELAY_MC_OVR_EN
        bus.ovr_en_i      = 1'b0;
        bus.ovr_dly_i     = '0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("reset_init");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Defaults: level source -> delay 1, three-cycle latency.
        idle(3);
        step(1'b1, 3, 1'b0, 0, 0, 1'b0);
        idle(10);
        // External source -> delay 2 with a three-cycle hold-off.
        step(1'b1, 7, 1'b0, 0, 0, 1'b0);
        idle(12);
        // Keep source: delay stays, no hold-off.
        step(1'b1, 0, 1'b0, 0, 0, 1'b0);
        idle(8);
        // Program the active source to 6.
        step(1'b1, 5, 1'b0, 0, 0, 1'b0);
        idle(6);
        step(1'b0, 0, 1'b1, 5, 6, 1'b0);
        idle(14);
        // Same value again: no hold-off.
        step(1'b0, 0, 1'b1, 5, 6, 1'b0);
        idle(6);
        // Write and trigger in one cycle.
        step(1'b1, 12, 1'b1, 12, 4, 1'b0);
        idle(10);

        rand_mode = 1'b1;
        rand_cycles(300);

        // Reset during hold-off.
        step(1'b0, 0, 1'b1, 4, 7, 1'b0);
        step(1'b1, 4, 1'b0, 0, 0, 1'b0);
        idle(3);
        pulse_reset("reset_holdoff");

        rand_mode = 1'b0;
        idle(4);
        step(1'b1, 6, 1'b0, 0, 0, 1'b0);
        idle(10);
        step(1'b1, 4, 1'b0, 0, 0, 1'b0);
        idle(8);

`ifdef RP_DELAY_MC_OVR_EN
        bus.ovr_dly_i = DLYW'(7);
        bus.ovr_en_i  = 1'b1;
        idle(4);
        step(1'b1, 9, 1'b0, 0, 0, 1'b0);
        idle(12);
        bus.ovr_en_i  = 1'b0;
        idle(10);
`endif

        rand_mode = 1'b1;
        rand_cycles(250);
        idle(DEPTH + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
